// File: rtl/wave_capture_buffer_pkg.sv
// Shared constants and helpers for the wave capture buffer.
// Optional ARMED timeout is enabled by defining WAVE_CAPTURE_TIMEOUT_EN.
package wave_capture_buffer_pkg;

    localparam logic [1:0] ARMED  = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    localparam int WAVE_WINDOW = 256;

    // Signed sample to unsigned display byte: flip the sign bit, keep the next 7 bits.
    function automatic logic [7:0] sample_to_byte(input logic sign_bit, input logic [6:0] upper_bits);
        return {~sign_bit, upper_bits};
    endfunction

endpackage

// File: rtl/wave_capture_buffer_if.sv
// Sample stream, vsync and renderer read port of the wave capture buffer.
interface wave_capture_buffer_if #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8
);
    // new_sample is a one-cycle strobe qualifying sample; there is no back-pressure,
    // every strobe is consumed in the cycle it is presented.
    logic                new_sample;
    logic [SAMPLE_W-1:0] sample;
    logic                vsync;
    logic [ADDR_W-1:0]   read_addr;
    logic [7:0]          read_data;
    logic                read_index;
    logic                capture_busy;
    logic                swap_pulse;

    modport master (
        output new_sample, sample, vsync, read_addr,
        input  read_data, read_index, capture_busy, swap_pulse
    );

    modport slave (
        input  new_sample, sample, vsync, read_addr,
        output read_data, read_index, capture_busy, swap_pulse
    );
endinterface

// File: rtl/wave_capture_ram.sv
// Two-half capture RAM: one write port, one registered read port, addressed {half, addr}.
module wave_capture_ram #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [ADDR_W:0] wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [ADDR_W:0] rd_addr,
    output logic [7:0]      rd_data
);

    logic [7:0] mem [2**(ADDR_W+1)];

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wave_capture_buffer.sv
// Zero-crossing triggered waveform capture into a double-buffered RAM, swapped on vsync.
// Define WAVE_CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_SAMPLES samples in ARMED.
module wave_capture_buffer
    import wave_capture_buffer_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int ADDR_W          = 8,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    wave_capture_buffer_if.slave        bus,
    output logic [1:0]                  dbg_state
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_cnt;
    logic              read_index;
    logic              prev_negative;
    logic              vsync_d;
    logic              swap_pulse;
    logic              sample_neg;
    logic              vsync_rise;
    logic              timeout_hit;
    logic              trigger;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [7:0]        wr_data;

    assign sample_neg = bus.sample[SAMPLE_W-1];
    assign vsync_rise = bus.vsync && !vsync_d;
    assign trigger    = (state == ARMED) && bus.new_sample &&
                        ((prev_negative && !sample_neg) || timeout_hit);

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TO_W-1:0] timeout_cnt;

    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_SAMPLES));

    // Held at zero outside ARMED, so every entry into ARMED starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else if (state != ARMED) begin
            timeout_cnt <= '0;
        end else if (bus.new_sample && !trigger) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_SAMPLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARMED;
            wr_cnt        <= '0;
            read_index    <= 1'b0;
            prev_negative <= 1'b0;
            vsync_d       <= 1'b0;
            swap_pulse    <= 1'b0;
        end else begin
            vsync_d    <= bus.vsync;
            swap_pulse <= 1'b0;
            if (bus.new_sample) begin
                prev_negative <= sample_neg;
            end
            case (state)
                ARMED: begin
                    if (trigger) begin
                        state  <= ACTIVE;
                        wr_cnt <= ADDR_W'(1);
                    end
                end
                ACTIVE: begin
                    // vsync edges here are deliberately not remembered.
                    if (bus.new_sample) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == '1) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (vsync_rise) begin
                        read_index <= ~read_index;
                        swap_pulse <= 1'b1;
                        state      <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase
        end
    end

    // The write half is always the one the renderer is not reading.
    assign wr_en   = trigger || ((state == ACTIVE) && bus.new_sample);
    assign wr_addr = {~read_index, (state == ACTIVE) ? wr_cnt : {ADDR_W{1'b0}}};
    assign wr_data = sample_to_byte(sample_neg, bus.sample[SAMPLE_W-2:SAMPLE_W-8]);

    logic unused_low_bits;
    assign unused_low_bits = ^bus.sample[SAMPLE_W-9:0];

    wave_capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr ({read_index, bus.read_addr}),
        .rd_data (bus.read_data)
    );

    assign bus.read_index   = read_index;
    assign bus.capture_busy = (state == ACTIVE) || (state == WAIT);
    assign bus.swap_pulse   = swap_pulse;
    assign dbg_state        = state;

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Sits between the music player's normalized sample stream and the wave display renderer.
- Triggers on a positive zero crossing, then captures one window of 256 samples into the write half of a two-half RAM. Each sample is truncated to 8-bit unsigned.
- On the next vsync rising edge after a window completes, swaps halves so the renderer always reads a complete, stable waveform.

Parameters:
- SAMPLE_W, 16, width of the incoming signed sample.
- ADDR_W, 8, log2 of window length (256 samples per half).
- TIMEOUT_SAMPLES, 4096, samples allowed in ARMED before a forced trigger (used only with the optional feature).

Ports:
- clk  input  1  system clock (100 MHz domain).
- reset  input  1  synchronous, active-high reset.
- new_sample  input  1  one-cycle strobe; sample is valid this cycle.
- sample  input  SAMPLE_W  signed two's-complement audio sample.
- vsync  input  1  display vertical sync level; its rising edge is the swap point.
- read_addr  input  ADDR_W  renderer read address.
- read_data  output  8  unsigned sample at read_addr in the read half.
- read_index  output  1  which half is currently the read half.
- capture_busy  output  1  high while in state ACTIVE or WAIT.
- swap_pulse  output  1  one-cycle pulse on the cycle read_index toggles.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=ARMED, read_index=0, write counter=0, prev_negative=0, capture_busy=0, swap_pulse=0, vsync_d=0.
  - read_data resets to 0 through its output register.
  - RAM contents are not cleared.
- Conversion: stored byte = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:SAMPLE_W-8]}.
  - Examples: 16'h8000 -> 8'h00, 16'h0000 -> 8'h80, 16'h7FFF -> 8'hFF.
- Zero-crossing detect (ARMED only):
  - On a new_sample cycle where prev_negative=1 and sample[MSB]=0, go to ACTIVE.
  - The triggering sample is written at address 0 of the write half (~read_index), and the counter becomes 1.
  - prev_negative updates on every new_sample, in all states.
- ACTIVE:
  - Each new_sample writes the converted byte at {~read_index, counter}, then the counter increments.
  - After the write at counter=255, the counter wraps to 0 and the state goes to WAIT.
  - Cycles without new_sample hold the state.
- WAIT:
  - Samples are ignored (no writes).
  - A vsync rising edge (vsync=1, vsync_d=0) toggles read_index, pulses swap_pulse for one cycle, and returns the state to ARMED.
- Boundary cases:
  - A vsync edge during ARMED or ACTIVE is ignored; there is no swap and read_index stays stable.
  - If the 256th write and a vsync edge land in the same cycle, the edge is not consumed; the swap waits for the next edge.
  - A zero crossing in the same cycle as the WAIT->ARMED transition does not trigger; the earliest trigger is on the next new_sample.
  - Reset mid-ACTIVE abandons the partial window; the read half holds its old data, but read_index forced to 0.
- Read port:
  - Synchronous with 1-cycle latency: read_data in cycle N+1 reflects read_addr in cycle N, from half read_index (as of cycle N).
  - Writes never target the read half, so there is no read/write collision.

Optional Feature:
- Macro: WAVE_CAPTURE_TIMEOUT_EN.
- Defined:
  - A sample counter runs in ARMED and increments per new_sample.
  - When it reaches TIMEOUT_SAMPLES without a crossing, the next new_sample triggers ACTIVE as if it were a crossing, so DC or silence still captures a flat line.
  - The counter clears on entering ARMED and on reset.
- Undefined: there is no timeout counter, and ARMED waits indefinitely for a crossing.

Decomposition:
- Shared package:
  - State enum: ARMED=2'd0, ACTIVE=2'd1, WAIT=2'd2.
  - WAVE_WINDOW=256 constant.
  - Sample-to-byte conversion function.
- Sub-module wave_capture_ram: one write port and one registered read port, depth 2*256, width 8, addressed {half, addr}.
- The FSM, counters and edge detector stay in wave_capture_buffer.

Test Plan:
- Reset, then samples -100, +50 -> ACTIVE.
  - Byte 8'h80 (from +50, i.e. 16'h0032) lands at write-half address 0.
  - capture_busy=1 the cycle after the strobe.
- Feed 256 samples ramping 16'h0000..16'h00FF after a trigger, then a vsync rise.
  - swap_pulse for one cycle; read_index 0->1.
  - read_addr 0..255 returns 8'h80 throughout, with 1-cycle latency.
- Drive a vsync edge in ARMED and mid-ACTIVE -> read_index unchanged, swap_pulse=0.
- Make the 256th write coincide with a vsync rise -> no swap that cycle; the swap occurs on the following vsync rise.
- Assert reset after 100 ACTIVE writes -> state ARMED, read_index=0, and the previous read half still returns its captured data.
- With WAVE_CAPTURE_TIMEOUT_EN and TIMEOUT_SAMPLES=8, feed constant +1000 -> ACTIVE entered on the 9th new_sample.
  - Without the macro, the same stimulus never leaves ARMED.
